// File: rtl/door_timer.sv
// Seconds-in-state timer for the door controller; counts whole seconds spent in OPEN/WAIT/CLOSE.
// Optional hold input enabled by defining DOOR_TIMER_PAUSE_EN.
`ifndef STATE_SIZE
`define STATE_SIZE 2
`endif
`ifndef IDLE
`define IDLE  3'd0
`endif
`ifndef OPEN
`define OPEN  3'd1
`endif
`ifndef WAIT
`define WAIT  3'd2
`endif
`ifndef CLOSE
`define CLOSE 3'd3
`endif
`ifndef PANIC
`define PANIC 3'd4
`endif

module door_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [`STATE_SIZE:0] state_reg,
`ifdef DOOR_TIMER_PAUSE_EN
  input  logic                 pause,
`endif
  output logic [`STATE_SIZE:0] sec_t,
  output logic                 sec_tick
);

  localparam int PRE_W = $clog2(TICKS_PER_SEC);
  localparam logic [PRE_W-1:0] TERMINAL = PRE_W'(TICKS_PER_SEC - 1);

  logic [`STATE_SIZE:0] state_prev;
  logic [PRE_W-1:0]     prescaler;
  logic [PRE_W-1:0]     prescaler_next;
  logic [`STATE_SIZE:0] sec_t_next;
  logic                 sec_tick_next;
  logic                 counting;

  always_comb begin
    counting = 1'b0;
    case (state_reg)
      `OPEN, `WAIT, `CLOSE: counting = 1'b1;
      default:              counting = 1'b0;
    endcase
  end

  // A state change or a non-counting state restarts the count; saturated sec_t just holds.
  always_comb begin
    prescaler_next = prescaler;
    sec_t_next     = sec_t;
    sec_tick_next  = 1'b0;
    if ((state_reg != state_prev) || !counting) begin
      prescaler_next = '0;
      sec_t_next     = '0;
`ifdef DOOR_TIMER_PAUSE_EN
    end else if (pause) begin
      prescaler_next = prescaler;
      sec_t_next     = sec_t;
`endif
    end else if (prescaler == TERMINAL) begin
      prescaler_next = '0;
      if (sec_t != '1) begin
        sec_t_next    = sec_t + 1'b1;
        sec_tick_next = 1'b1;
      end
    end else begin
      prescaler_next = prescaler + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_prev <= `IDLE;
      prescaler  <= '0;
      sec_t      <= '0;
      sec_tick   <= 1'b0;
    end else begin
      state_prev <= state_reg;
      prescaler  <= prescaler_next;
      sec_t      <= sec_t_next;
      sec_tick   <= sec_tick_next;
    end
  end

endmodule

// File: tb/tb_door_timer.sv
// Directed plus randomized bench for door_timer (TICKS_PER_SEC=4), checked against an
// elapsed-edge model: sec_t is the number of whole seconds counted since the last restart.
`ifndef STATE_SIZE
`define STATE_SIZE 2
`endif
`ifndef IDLE
`define IDLE  3'd0
`endif
`ifndef OPEN
`define OPEN  3'd1
`endif
`ifndef WAIT
`define WAIT  3'd2
`endif
`ifndef CLOSE
`define CLOSE 3'd3
`endif
`ifndef PANIC
`define PANIC 3'd4
`endif

module tb_door_timer;

  localparam int T       = 4;
  localparam int SEC_MAX = (2 ** (`STATE_SIZE + 1)) - 1;

  logic                 clk;
  logic                 rst_n;
  logic [`STATE_SIZE:0] state_reg;
  logic                 pause;
  logic [`STATE_SIZE:0] sec_t;
  logic                 sec_tick;

  int errors;
  int checks;

  int                   elapsed;
  logic [`STATE_SIZE:0] model_prev;
  logic [`STATE_SIZE:0] exp_t;
  logic                 exp_tick;
  int                   tick_count;

  door_timer #(.TICKS_PER_SEC(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .state_reg(state_reg),
`ifdef DOOR_TIMER_PAUSE_EN
    .pause    (pause),
`endif
    .sec_t    (sec_t),
    .sec_tick (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_counting(input logic [`STATE_SIZE:0] s);
    return (s == `OPEN) || (s == `WAIT) || (s == `CLOSE);
  endfunction

  task automatic modelReset();
    elapsed    = 0;
    model_prev = `IDLE;
    exp_t      = '0;
    exp_tick   = 1'b0;
  endtask

  // One clock edge of the reference: counted edges since the last restart, seconds derived by division.
  task automatic modelEdge(input logic [`STATE_SIZE:0] s, input logic p);
    bit advanced;
    advanced = 1'b0;
    if (!is_counting(s) || (s != model_prev)) begin
      elapsed = 0;
    end else begin
`ifdef DOOR_TIMER_PAUSE_EN
      if (!p) begin
        elapsed++;
        advanced = 1'b1;
      end
`else
      elapsed++;
      advanced = 1'b1;
`endif
    end
    model_prev = s;
    exp_t    = (elapsed / T > SEC_MAX) ? SEC_MAX[`STATE_SIZE:0] : (`STATE_SIZE+1)'(elapsed / T);
    exp_tick = advanced && (elapsed % T == 0) && (elapsed / T <= SEC_MAX);
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (sec_t === exp_t) else begin
      errors++;
      $error("[TB] FAIL %s sec_t: got %0d expected %0d (t=%0t)", tag, sec_t, exp_t, $time);
    end
    checks++;
    assert (sec_tick === exp_tick) else begin
      errors++;
      $error("[TB] FAIL %s sec_tick: got %0b expected %0b (t=%0t)", tag, sec_tick, exp_tick, $time);
    end
    if (sec_tick === 1'b1) tick_count++;
  endtask

  task automatic applyStimulus(input logic [`STATE_SIZE:0] s, input logic p, input int cycles,
                               input string tag);
    for (int i = 0; i < cycles; i++) begin
      state_reg = s;
      pause     = p;
      @(posedge clk);
      modelEdge(s, p);
      #1;
      checkOutput(tag);
    end
  endtask

  task automatic checkConst(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  initial begin
    logic [`STATE_SIZE:0] rs;
    logic                 rp;
    int                   rn;
    errors     = 0;
    checks     = 0;
    tick_count = 0;
    state_reg  = `IDLE;
    pause      = 1'b0;
    rst_n      = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(`IDLE, 1'b0, 20, "idle20");
    checkConst("idle_no_ticks", tick_count, 0);

    // Change edge, then pulses at +4 and +8.
    applyStimulus(`OPEN, 1'b0, 1, "open_change");
    applyStimulus(`OPEN, 1'b0, 3, "open_pre");
    applyStimulus(`OPEN, 1'b0, 1, "open_sec1");
    checkConst("open_sec1_val", int'(sec_t), 1);
    checkConst("open_sec1_tick", int'(sec_tick), 1);
    applyStimulus(`OPEN, 1'b0, 1, "open_after1");
    checkConst("open_tick_width", int'(sec_tick), 0);
    applyStimulus(`OPEN, 1'b0, 2, "open_mid");
    applyStimulus(`OPEN, 1'b0, 1, "open_sec2");
    checkConst("open_sec2_val", int'(sec_t), 2);

    // Reach sec_t=3, then switch on the terminal-count edge.
    applyStimulus(`OPEN, 1'b0, 7, "open_to3");
    checkConst("open_sec3_val", int'(sec_t), 3);
    applyStimulus(`WAIT, 1'b0, 1, "wait_on_terminal");
    checkConst("wait_clear_val", int'(sec_t), 0);
    checkConst("wait_clear_tick", int'(sec_tick), 0);
    applyStimulus(`WAIT, 1'b0, 4, "wait_count");
    checkConst("wait_sec1", int'(sec_t), 1);

    // Saturation in CLOSE.
    applyStimulus(`CLOSE, 1'b0, 4 * (SEC_MAX + 1 + 2), "close_sat");
    checkConst("close_saturated", int'(sec_t), SEC_MAX);

    // Asynchronous reset mid-count.
    applyStimulus(`PANIC, 1'b0, 2, "panic");
    applyStimulus(`OPEN, 1'b0, 11, "open_pre_reset");
    checkConst("pre_reset_sec", int'(sec_t), 2);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(`OPEN, 1'b0, 1, "post_reset_change");
    applyStimulus(`OPEN, 1'b0, 4, "post_reset_count");
    checkConst("post_reset_sec1", int'(sec_t), 1);

`ifdef DOOR_TIMER_PAUSE_EN
    applyStimulus(`IDLE, 1'b0, 1, "pause_prep");
    applyStimulus(`OPEN, 1'b0, 2, "pause_pre");
    applyStimulus(`OPEN, 1'b1, 10, "pause_hold");
    applyStimulus(`OPEN, 1'b0, 3, "pause_release");
    checkConst("pause_release_sec1", int'(sec_t), 1);
    applyStimulus(`OPEN, 1'b1, 3, "pause_hold2");
    applyStimulus(`CLOSE, 1'b1, 1, "pause_change");
    checkConst("pause_change_clear", int'(sec_t), 0);
`endif

    // Random segments of held states with optional pause.
    for (int seg = 0; seg < 40; seg++) begin
      rs = 3'($urandom_range(0, 7));
      rn = int'($urandom_range(1, 14));
`ifdef DOOR_TIMER_PAUSE_EN
      rp = 1'($urandom_range(0, 1));
`else
      rp = 1'b0;
`endif
      applyStimulus(rs, rp, rn, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
